// File: rtl/pattern_encoder.sv
// Pattern token compiler: validates a token stream and writes one 8-bit
// pattern word per token into the pattern RAM, closing the program with END.
module pattern_encoder #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          tok_valid,
  output logic          tok_ready,
  input  logic [2:0]    tok_op,
  input  logic [3:0]    tok_arg,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_wdata,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code,
  output logic [AW:0]   length
);

  localparam int unsigned LW = AW + 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] RUN   = 3'd1;
  localparam logic [2:0] GROUP = 3'd2;
  localparam logic [2:0] DONE  = 3'd3;
  localparam logic [2:0] ERR   = 3'd4;

  localparam logic [2:0] OP_LIT    = 3'd0;
  localparam logic [2:0] OP_ANY    = 3'd1;
  localparam logic [2:0] OP_NEXT2  = 3'd2;
  localparam logic [2:0] OP_NEXT3  = 3'd3;
  localparam logic [2:0] OP_EXACT  = 3'd4;
  localparam logic [2:0] OP_UPTO   = 3'd5;
  localparam logic [2:0] OP_FINISH = 3'd6;

  localparam logic [1:0] ERR_BAD   = 2'd1;
  localparam logic [1:0] ERR_GROUP = 2'd2;
  localparam logic [1:0] ERR_FULL  = 2'd3;

  logic [2:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [LW-1:0] len_d;
  logic          we_q, we_d;
  logic [AW-1:0] maddr_d;
  logic [7:0]    wdata_d;
  logic          done_d, error_d, ready_d;
  logic [1:0]    code_d;
  logic [7:0]    word;
  logic          bad, full, hs;

  // Reset is sampled synchronously, but a write registered just before it
  // must not reach the RAM.
  assign mem_we = we_q & ~reset;

  assign hs   = tok_valid & tok_ready & ~start;
  assign full = (addr_q == AW'(DEPTH - 1));
  assign bad  = (tok_op == 3'd7) ||
                (((tok_op == OP_EXACT) || (tok_op == OP_UPTO)) && (tok_arg == 4'd0));

  // Token to pattern word
  always_comb begin
    word = 8'h00;
    case (tok_op)
      OP_LIT:   word = {6'b000100, tok_arg[1:0]};
      OP_ANY:   word = 8'h20;
      OP_NEXT2: word = 8'h21;
      OP_NEXT3: word = 8'h22;
      OP_EXACT: word = {4'h0, tok_arg};
      OP_UPTO:  word = {4'h3, 4'(5'd16 - 5'(tok_arg))};
      default:  word = 8'h00;
    endcase
  end

  // Next state and next register values
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    len_d   = length;
    we_d    = 1'b0;
    maddr_d = mem_addr;
    wdata_d = mem_wdata;
    done_d  = done;
    error_d = error;
    code_d  = err_code;
    if (start) begin
      state_d = RUN;
      cnt_d   = 2'd0;
      addr_d  = '0;
      len_d   = '0;
      done_d  = 1'b0;
      error_d = 1'b0;
      code_d  = 2'd0;
    end else if (hs) begin
      if ((state_q == GROUP) && (tok_op != OP_LIT)) begin
        state_d = ERR;
        error_d = 1'b1;
        code_d  = ERR_GROUP;
      end else if ((state_q != GROUP) && bad) begin
        state_d = ERR;
        error_d = 1'b1;
        code_d  = ERR_BAD;
      end else if (full && (tok_op != OP_FINISH)) begin
        state_d = ERR;
        error_d = 1'b1;
        code_d  = ERR_FULL;
      end else begin
        we_d    = 1'b1;
        maddr_d = addr_q;
        wdata_d = word;
        addr_d  = addr_q + AW'(1);
        len_d   = length + LW'(1);
        if (state_q == GROUP) begin
          cnt_d = cnt_q - 2'd1;
          if (cnt_q == 2'd1) state_d = RUN;
        end else begin
          case (tok_op)
            OP_NEXT2: begin state_d = GROUP; cnt_d = 2'd2; end
            OP_NEXT3: begin state_d = GROUP; cnt_d = 2'd3; end
            OP_FINISH: begin state_d = DONE; done_d = 1'b1; end
            default: ;
          endcase
        end
      end
    end
    ready_d = (state_d == RUN) || (state_d == GROUP);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= 2'd0;
      addr_q    <= '0;
      length    <= '0;
      we_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 8'h00;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= 2'd0;
      tok_ready <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      length    <= len_d;
      we_q      <= we_d;
      mem_addr  <= maddr_d;
      mem_wdata <= wdata_d;
      done      <= done_d;
      error     <= error_d;
      err_code  <= code_d;
      tok_ready <= ready_d;
    end
  end

endmodule

// File: tb/tb_pattern_encoder.sv
// Bench for pattern_encoder (DEPTH = 4): expected RAM writes go into a queue
// that a negedge monitor drains; status outputs are checked inline.
module tb_pattern_encoder;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          tok_valid = 1'b0;
  logic          tok_ready;
  logic [2:0]    tok_op = 3'd0;
  logic [3:0]    tok_arg = 4'd0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          done, error;
  logic [1:0]    err_code;
  logic [AW:0]   length;

  int vectors = 0;
  int miscompares = 0;
  logic [AW+7:0] exp_q[$];

  pattern_encoder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clock(clock), .reset(reset), .start(start),
    .tok_valid(tok_valid), .tok_ready(tok_ready),
    .tok_op(tok_op), .tok_arg(tok_arg),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .done(done), .error(error), .err_code(err_code), .length(length)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish (got running, required finished)");
    $fatal(1);
  end

  // Monitor: every write must match the oldest expected write
  always @(negedge clock) begin
    if (mem_we === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_write: got addr %0d data %02h, required no write", mem_addr, mem_wdata);
      end else begin
        logic [AW+7:0] e;
        e = exp_q.pop_front();
        if ({mem_addr, mem_wdata} !== e) begin
          miscompares++;
          $display("FAIL write: got addr %0d data %02h, required addr %0d data %02h",
                   mem_addr, mem_wdata, e[AW+7:8], e[7:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input int a, input logic [7:0] d);
    exp_q.push_back({AW'(a), d});
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  // Present one token and wait (bounded) for it to be taken
  task automatic send(input logic [2:0] op, input logic [3:0] arg);
    int n;
    @(negedge clock);
    tok_valid = 1'b1;
    tok_op    = op;
    tok_arg   = arg;
    n = 0;
    while (tok_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (n == 20) chk("handshake_timeout", 32'(tok_ready), 32'd1);
    @(negedge clock);
    tok_valid = 1'b0;
  endtask

  task automatic chk_status(input string tag, input logic d, input logic e,
                            input logic [1:0] c, input int len);
    chk({tag, "_done"}, 32'(done), 32'(d));
    chk({tag, "_error"}, 32'(error), 32'(e));
    chk({tag, "_err_code"}, 32'(err_code), 32'(c));
    chk({tag, "_length"}, 32'(length), 32'(len));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_tok_ready"}, 32'(tok_ready), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    chk_status(tag, 1'b0, 1'b0, 2'd0, 0);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    chk_all_zero("reset");
    reset = 1'b0;
    @(negedge clock);
    chk_all_zero("idle");

    // 1: basic program ending with END in the reserved last slot
    do_start();
    chk("run_ready", 32'(tok_ready), 32'd1);
    expect_wr(0, 8'h12); expect_wr(1, 8'h20); expect_wr(2, 8'h05); expect_wr(3, 8'h00);
    send(3'd0, 4'd2); send(3'd1, 4'd0); send(3'd4, 4'd5); send(3'd6, 4'd0);
    chk_status("t1", 1'b1, 1'b0, 2'd0, 4);
    chk("t1_ready", 32'(tok_ready), 32'd0);

    // 2: UPTO encoding, then UPTO 0 is a bad token
    do_start();
    expect_wr(0, 8'h3D); expect_wr(1, 8'h31); expect_wr(2, 8'h00);
    send(3'd5, 4'd3); send(3'd5, 4'd15); send(3'd6, 4'd0);
    chk_status("t2a", 1'b1, 1'b0, 2'd0, 3);
    do_start();
    chk_status("t2_cleared", 1'b0, 1'b0, 2'd0, 0);
    send(3'd5, 4'd0);
    chk_status("t2b", 1'b0, 1'b1, 2'd1, 0);
    chk("t2b_ready", 32'(tok_ready), 32'd0);

    // illegal opcode 7 and EXACT 15
    do_start();
    expect_wr(0, 8'h0F);
    send(3'd4, 4'd15); send(3'd7, 4'd0);
    chk_status("op7", 1'b0, 1'b1, 2'd1, 1);

    // 3: non-LIT inside a NEXT3 group
    do_start();
    expect_wr(0, 8'h22); expect_wr(1, 8'h10); expect_wr(2, 8'h11);
    send(3'd3, 4'd0); send(3'd0, 4'd0); send(3'd0, 4'd1); send(3'd1, 4'd0);
    chk_status("t3", 1'b0, 1'b1, 2'd2, 3);

    // NEXT2 group completes and returns to RUN
    do_start();
    expect_wr(0, 8'h21); expect_wr(1, 8'h13); expect_wr(2, 8'h10); expect_wr(3, 8'h00);
    send(3'd2, 4'd0); send(3'd0, 4'd3); send(3'd0, 4'd0); send(3'd6, 4'd0);
    chk_status("next2", 1'b1, 1'b0, 2'd0, 4);

    // 4: memory full, then FINISH in the last slot
    do_start();
    expect_wr(0, 8'h13); expect_wr(1, 8'h13); expect_wr(2, 8'h13);
    send(3'd0, 4'd3); send(3'd0, 4'd3); send(3'd0, 4'd3); send(3'd0, 4'd0);
    chk_status("t4a", 1'b0, 1'b1, 2'd3, 3);
    do_start();
    expect_wr(0, 8'h13); expect_wr(1, 8'h13); expect_wr(2, 8'h13); expect_wr(3, 8'h00);
    send(3'd0, 4'd3); send(3'd0, 4'd3); send(3'd0, 4'd3); send(3'd6, 4'd0);
    chk_status("t4b", 1'b1, 1'b0, 2'd0, 4);

    // 5: FINISH held valid in DONE and across a start pulse
    @(negedge clock);
    tok_valid = 1'b1; tok_op = 3'd6; tok_arg = 4'd0;
    repeat (3) @(negedge clock);
    chk("t5_done_ready", 32'(tok_ready), 32'd0);
    chk("t5_done_held", 32'(done), 32'd1);
    expect_wr(0, 8'h00);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk_status("t5_after_start", 1'b0, 1'b0, 2'd0, 0);
    chk("t5_ready", 32'(tok_ready), 32'd1);
    @(negedge clock);
    tok_valid = 1'b0;
    chk_status("t5_finish", 1'b1, 1'b0, 2'd0, 1);

    // token presented together with start while already running is ignored
    do_start();
    @(negedge clock);
    start = 1'b1; tok_valid = 1'b1; tok_op = 3'd0; tok_arg = 4'd1;
    @(negedge clock);
    start = 1'b0; tok_valid = 1'b0;
    chk("start_tok_length", 32'(length), 32'd0);

    // 6: reset right after a LIT1 handshake suppresses the write
    @(negedge clock);
    tok_valid = 1'b1; tok_op = 3'd0; tok_arg = 4'd1;
    @(posedge clock);
    #1;
    reset = 1'b1;
    tok_valid = 1'b0;
    @(negedge clock);
    chk("t6_we_suppressed", 32'(mem_we), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    chk_all_zero("t6_reset");
    repeat (2) @(negedge clock);
    chk("t6_ready_idle", 32'(tok_ready), 32'd0);

    repeat (2) @(negedge clock);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
